jtag_pin_sampler: RTL and testbench

- Oversampling front end for the JTAG TAP, running in the system clock domain.
- Consumes the outputs of the 2-FF synchronisers on TCK/TMS/TDI.
- Glitch-filters TCK, produces single-cycle rising/falling strobes, and captures TMS/TDI aligned to the filtered rising edge.
- Launches TDO on the filtered falling edge; the TAP FSM downstream runs purely on the strobes.

---
 rtl/jtag_pin_sampler.sv | 101 ++++++++++
 tb/tb_jtag_pin_sampler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_pin_sampler.sv
// jtag_pin_sampler: oversampling TCK glitch filter with rise/fall strobes,
// TMS/TDI capture aligned to the filtered rising edge and TDO launch on the
// filtered falling edge, all in the system clock domain.
// Ports: clk, rst_p (sync, active high), tck_sync/tms_sync/tdi_sync
// (synchronised pins), tdo_next (next TDO bit) -> tck_level, tck_rise,
// tck_fall, tms_q, tdi_q, tdo.
// Optional macro JTAG_PIN_SAMPLER_TRST_EN adds trst_n_sync (active-low TRST)
// and the registered tap_reset output.
module jtag_pin_sampler #(
    parameter int FILT_CNT = 2,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_p,
    input  logic tck_sync,
    input  logic tms_sync,
    input  logic tdi_sync,
    input  logic tdo_next,
`ifdef JTAG_PIN_SAMPLER_TRST_EN
    input  logic trst_n_sync,
    output logic tap_reset,
`endif
    output logic tck_level,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_q,
    output logic tdi_q,
    output logic tdo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

    logic [CNT_W-1:0] cnt;
    logic             tms_cap;
    logic             tdi_cap;
    logic             mismatch;
    logic             first;
    logic             qualify;
    logic             trst_act;

    assign mismatch = (tck_sync != tck_level);
    assign first    = mismatch && (cnt == '0);
    assign qualify  = mismatch && (cnt == CNT_LAST);

`ifdef JTAG_PIN_SAMPLER_TRST_EN
    assign trst_act = ~trst_n_sync;
`else
    assign trst_act = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_p) begin
            tck_level <= 1'b0;
            tck_rise  <= 1'b0;
            tck_fall  <= 1'b0;
            cnt       <= '0;
            tms_cap   <= 1'b0;
            tdi_cap   <= 1'b0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
            tdo       <= 1'b0;
`ifdef JTAG_PIN_SAMPLER_TRST_EN
            tap_reset <= 1'b1;
`endif
        end else begin
            tck_rise <= 1'b0;
            tck_fall <= 1'b0;
            // First sample of a candidate rising edge is the one that counts.
            if (first && !tck_level) begin
                tms_cap <= tms_sync;
                tdi_cap <= tdi_sync;
            end
            if (trst_act) begin
                tck_level <= 1'b0;
                cnt       <= '0;
                tdo       <= 1'b0;
            end else if (!mismatch) begin
                cnt <= '0;
            end else if (qualify) begin
                tck_level <= tck_sync;
                cnt       <= '0;
                if (tck_sync) begin
                    tck_rise <= 1'b1;
                    // With a one-cycle filter the capture register is
                    // loaded on this same edge, so take the live sample.
                    tms_q <= first ? tms_sync : tms_cap;
                    tdi_q <= first ? tdi_sync : tdi_cap;
                end else begin
                    tck_fall <= 1'b1;
                    tdo      <= tdo_next;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
`ifdef JTAG_PIN_SAMPLER_TRST_EN
            tap_reset <= trst_act;
`endif
        end
    end

endmodule

// File: tb/tb_jtag_pin_sampler.sv
// tb_jtag_pin_sampler: directed stimulus for jtag_pin_sampler with a
// window-based reference model checked every cycle plus literal spot checks.
module tb_jtag_pin_sampler;

    logic clk = 1'b0;
    logic rst_p = 1'b1;
    logic tck = 1'b0;
    logic tms = 1'b0;
    logic tdi = 1'b0;
    logic tdo_next = 1'b0;
    logic trst_n = 1'b1;

    logic lvl2, rise2, fall2, tmsq2, tdiq2, tdo2;
    logic lvl3, rise3, fall3, tmsq3, tdiq3, tdo3;
    logic tap2, tap3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtag_pin_sampler #(.FILT_CNT(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_p(rst_p), .tck_sync(tck), .tms_sync(tms),
        .tdi_sync(tdi), .tdo_next(tdo_next),
`ifdef JTAG_PIN_SAMPLER_TRST_EN
        .trst_n_sync(trst_n), .tap_reset(tap2),
`endif
        .tck_level(lvl2), .tck_rise(rise2), .tck_fall(fall2),
        .tms_q(tmsq2), .tdi_q(tdiq2), .tdo(tdo2)
    );

    jtag_pin_sampler #(.FILT_CNT(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst_p(rst_p), .tck_sync(tck), .tms_sync(tms),
        .tdi_sync(tdi), .tdo_next(tdo_next),
`ifdef JTAG_PIN_SAMPLER_TRST_EN
        .trst_n_sync(trst_n), .tap_reset(tap3),
`endif
        .tck_level(lvl3), .tck_rise(rise3), .tck_fall(fall3),
        .tms_q(tmsq3), .tdi_q(tdiq3), .tdo(tdo3)
    );

`ifndef JTAG_PIN_SAMPLER_TRST_EN
    assign tap2 = 1'b0;
    assign tap3 = 1'b0;
`endif

    // Reference model: the level flips once the last F samples taken since
    // the previous flip/reset all disagree with it; TMS/TDI come from the
    // first of those F samples.
    int   e = 0;
    logic h_tck [64];
    logic h_tms [64];
    logic h_tdi [64];
    int   last  [2];
    logic m_lvl [2];
    logic m_rise[2];
    logic m_fall[2];
    logic m_tms [2];
    logic m_tdi [2];
    logic m_tdo [2];
    logic m_tap [2];

    always @(posedge clk) begin
        e = e + 1;
        h_tck[e % 64] = tck;
        h_tms[e % 64] = tms;
        h_tdi[e % 64] = tdi;
        for (int i = 0; i < 2; i++) begin
            int  f;
            bit  run;
            f = (i == 0) ? 2 : 3;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (rst_p) begin
                m_lvl[i] = 1'b0;
                m_tms[i] = 1'b0;
                m_tdi[i] = 1'b0;
                m_tdo[i] = 1'b0;
                m_tap[i] = 1'b1;
                last[i]  = e;
            end else begin
`ifdef JTAG_PIN_SAMPLER_TRST_EN
                m_tap[i] = !trst_n;
`else
                m_tap[i] = 1'b0;
`endif
                if (m_tap[i]) begin
                    m_lvl[i] = 1'b0;
                    m_tdo[i] = 1'b0;
                    last[i]  = e;
                end else begin
                    run = 1'b1;
                    for (int k = 0; k < f; k++) begin
                        if (e - k <= last[i]) run = 1'b0;
                        else if (h_tck[(e - k) % 64] == m_lvl[i]) run = 1'b0;
                    end
                    if (run) begin
                        m_lvl[i] = !m_lvl[i];
                        last[i]  = e;
                        if (m_lvl[i]) begin
                            m_rise[i] = 1'b1;
                            m_tms[i]  = h_tms[(e - f + 1) % 64];
                            m_tdi[i]  = h_tdi[(e - f + 1) % 64];
                        end else begin
                            m_fall[i] = 1'b1;
                            m_tdo[i]  = tdo_next;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (e > 0) begin
            check("m2_level", lvl2,  m_lvl[0]);
            check("m2_rise",  rise2, m_rise[0]);
            check("m2_fall",  fall2, m_fall[0]);
            check("m2_tms",   tmsq2, m_tms[0]);
            check("m2_tdi",   tdiq2, m_tdi[0]);
            check("m2_tdo",   tdo2,  m_tdo[0]);
            check("m3_level", lvl3,  m_lvl[1]);
            check("m3_rise",  rise3, m_rise[1]);
            check("m3_fall",  fall3, m_fall[1]);
            check("m3_tms",   tmsq3, m_tms[1]);
            check("m3_tdi",   tdiq3, m_tdi[1]);
            check("m3_tdo",   tdo3,  m_tdo[1]);
            check("m_both",   rise2 & fall2, 1'b0);
`ifdef JTAG_PIN_SAMPLER_TRST_EN
            check("m2_tap",   tap2,  m_tap[0]);
            check("m3_tap",   tap3,  m_tap[1]);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv();
        @(negedge clk);
    endtask

    initial begin
        tick();
        tick();
        check("rst_level", lvl2, 1'b0);
        check("rst_rise",  rise2, 1'b0);
        check("rst_tdo",   tdo2, 1'b0);
        check("rst_tms",   tmsq2, 1'b0);
        drv(); rst_p = 1'b0;
        tick(); tick(); tick();

        // Clean rise with TMS=1, TDI=0.
        drv(); tck = 1'b1; tms = 1'b1; tdi = 1'b0;
        tick();
        check("r1_rise_early", rise2, 1'b0);
        tick();
        check("r1_rise", rise2, 1'b1);
        check("r1_level", lvl2, 1'b1);
        check("r1_tms", tmsq2, 1'b1);
        check("r1_tdi", tdiq2, 1'b0);
        check("r1_fall", fall2, 1'b0);
        tick();
        check("r1_single", rise2, 1'b0);
        check("r1_rise3", rise3, 1'b1);

        // Fall launches TDO, then TDO holds without a fall.
        drv(); tck = 1'b0; tdo_next = 1'b1;
        tick();
        check("f_early", fall2, 1'b0);
        tick();
        check("f_fall", fall2, 1'b1);
        check("f_tdo", tdo2, 1'b1);
        drv(); tdo_next = 1'b0;
        tick();
        check("f_single", fall2, 1'b0);
        check("f_hold", tdo2, 1'b1);
        tick();
        check("f_hold2", tdo2, 1'b1);

        // One-cycle glitch is ignored; clean rise still qualifies.
        drv(); tck = 1'b1;
        drv(); tck = 1'b0;
        tick();
        tick();
        check("g_level", lvl2, 1'b0);
        check("g_rise", rise2, 1'b0);
        drv(); tck = 1'b1;
        tick();
        check("g2_early", rise2, 1'b0);
        tick();
        check("g2_rise", rise2, 1'b1);

        // TMS/TDI change after the first sample; first sample wins.
        drv(); tck = 1'b0;
        repeat (4) tick();
        drv(); tck = 1'b1; tms = 1'b1; tdi = 1'b1;
        tick();
        drv(); tms = 1'b0; tdi = 1'b0;
        tick();
        check("c_rise2", rise2, 1'b1);
        check("c_tms2", tmsq2, 1'b1);
        tick();
        check("c_rise3", rise3, 1'b1);
        check("c_tms3", tmsq3, 1'b1);
        check("c_tdi3", tdiq3, 1'b1);

        // Reset in the middle of a qualifying rise.
        drv(); tck = 1'b0;
        repeat (4) tick();
        drv(); tck = 1'b1;
        tick();
        drv(); rst_p = 1'b1;
        tick();
        check("rr_rise", rise2, 1'b0);
        check("rr_level", lvl2, 1'b0);
        check("rr_tms", tmsq2, 1'b0);
        drv(); rst_p = 1'b0;
        tick();
        check("rr_early", rise2, 1'b0);
        tick();
        check("rr_rise2", rise2, 1'b1);

`ifdef JTAG_PIN_SAMPLER_TRST_EN
        drv(); trst_n = 1'b0;
        tick();
        check("t_tap", tap2, 1'b1);
        check("t_tdo", tdo2, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) begin
                drv(); tck = !tck;
            end
            tick();
            check("t_norise", rise2, 1'b0);
            check("t_nofall", fall2, 1'b0);
            check("t_tap_h", tap2, 1'b1);
        end
        drv(); tck = 1'b1; trst_n = 1'b1;
        tick();
        check("t_rel_tap", tap2, 1'b0);
        check("t_rel_early", rise2, 1'b0);
        tick();
        check("t_rel_rise", rise2, 1'b1);
`endif

        // Free-running toggles with varying pulse widths for the model.
        for (int i = 0; i < 40; i++) begin
            drv();
            tck = (i % 7 < 3) || (i % 11 == 5);
            tms = i[0];
            tdi = i[1];
            tdo_next = i[2];
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
